// File: rtl/multicycle_control_fsm.sv
// Main control unit for the multicycle RV32I datapath: sequences each instruction
// through its states and drives datapath selects, write enables and the ALU code.
module multicycle_control_fsm #(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALU_control,
  output logic       illegal_op
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
  } state_e;

  state_e state_q, state_d;

  logic       legal;
  logic       pc_update, branch;
  logic       adr_src, mem_write, ir_write, reg_write, trap;
  logic [1:0] result_src, src_a, src_b;
  logic [2:0] alu_ctl, alu_dec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    legal = 1'b0;
    unique case (op)
      OP_LW, OP_SW: legal = (funct3 == 3'b010);
      OP_R, OP_I:   legal = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                            (funct3 == 3'b110) || (funct3 == 3'b111);
      OP_BEQ:       legal = (funct3 == 3'b000);
      OP_JAL:       legal = 1'b1;
      default:      legal = 1'b0;
    endcase
  end

  // funct7b5 selects SUB only for register-register ops; addi never subtracts.
  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3)
      3'b000:  alu_dec = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    trap       = 1'b0;
    result_src = 2'b00;
    src_a      = 2'b00;
    src_b      = 2'b00;
    alu_ctl    = ALU_ADD;
    unique case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        src_b      = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        src_a = 2'b01;
        src_b = 2'b01;
        if (!legal) begin
          state_d = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
        end else begin
          unique case (op)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_R:         state_d = S_EXECUTER;
            OP_I:         state_d = S_EXECUTEI;
            OP_BEQ:       state_d = S_BEQ;
            default:      state_d = S_JAL;
          endcase
        end
      end
      S_MEMADR: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECUTER: begin
        src_a   = 2'b10;
        alu_ctl = alu_dec;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        alu_ctl = alu_dec;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        src_a   = 2'b10;
        alu_ctl = ALU_SUB;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        src_a     = 2'b01;
        src_b     = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_TRAP: begin
        trap    = 1'b1;
        state_d = S_TRAP;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    unique case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Reset forces the enables low directly so nothing writes while the state register is held.
  assign PCWrite     = ~reset & (pc_update | (branch & Zero));
  assign MemWrite    = ~reset & mem_write;
  assign IRWrite     = ~reset & ir_write;
  assign RegWrite    = ~reset & reg_write;
  assign illegal_op  = ~reset & trap;
  assign AdrSrc      = adr_src;
  assign ResultSrc   = result_src;
  assign ALUSrcA     = src_a;
  assign ALUSrcB     = src_b;
  assign ALU_control = alu_ctl;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: two instances (trap / no-trap) share
// stimulus; per-cycle expected control words are queued and checked by a monitor.
module tb_multicycle_control_fsm;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef logic [16:0] vec_t;
  typedef enum {K_RST, K_F, K_D, K_MA, K_MR, K_MWB, K_MW, K_XR, K_XI, K_WB,
                K_BEQ, K_JAL, K_TRAP} kind_e;

  logic clk = 1'b0;
  logic reset, funct7b5, Zero;
  logic [6:0] op;
  logic [2:0] funct3;

  logic       pcw0, adr0, mw0, irw0, rw0, ill0, pcw1, adr1, mw1, irw1, rw1, ill1;
  logic [1:0] res0, sa0, sb0, imm0, res1, sa1, sb1, imm1;
  logic [2:0] alu0, alu1;
  vec_t       vec0, vec1;

  multicycle_control_fsm #(.ILLEGAL_TRAP(1'b0)) dut0 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(mw0), .IRWrite(irw0), .RegWrite(rw0),
    .ResultSrc(res0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ImmSrc(imm0), .ALU_control(alu0),
    .illegal_op(ill0));

  multicycle_control_fsm #(.ILLEGAL_TRAP(1'b1)) dut1 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(pcw1), .AdrSrc(adr1), .MemWrite(mw1), .IRWrite(irw1), .RegWrite(rw1),
    .ResultSrc(res1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ImmSrc(imm1), .ALU_control(alu1),
    .illegal_op(ill1));

  assign vec0 = {pcw0, adr0, mw0, irw0, rw0, res0, sa0, sb0, imm0, alu0, ill0};
  assign vec1 = {pcw1, adr1, mw1, irw1, rw1, res1, sa1, sb1, imm1, alu1, ill1};

  always #5 clk = ~clk;

  vec_t  q0[$], q1[$];
  kind_e k0q[$], k1q[$];
  int tests = 0;
  int fails = 0;

  function automatic bit legal(logic [6:0] o, logic [2:0] f3);
    if (o == OP_LW || o == OP_SW) return f3 == 3'd2;
    if (o == OP_R || o == OP_I)   return f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7;
    if (o == OP_BEQ)              return f3 == 3'd0;
    return o == OP_JAL;
  endfunction

  // Expected control word for one step of an instruction, straight from the step table.
  function automatic vec_t expect_out(kind_e k, logic [6:0] o, logic [2:0] f3, logic f7, logic z);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] alu;
    {pcw, adr, mw, irw, rw, ill} = '0;
    {res, sa, sb} = '0;
    alu = 3'b000;
    imm = (o == OP_SW) ? 2'd1 : (o == OP_BEQ) ? 2'd2 : (o == OP_JAL) ? 2'd3 : 2'd0;
    case (k)
      K_RST:  begin sb = 2'b10; res = 2'b10; end
      K_F:    begin irw = 1; pcw = 1; sb = 2'b10; res = 2'b10; end
      K_D:    begin sa = 2'b01; sb = 2'b01; end
      K_MA:   begin sa = 2'b10; sb = 2'b01; end
      K_MR:   adr = 1;
      K_MWB:  begin res = 2'b01; rw = 1; end
      K_MW:   begin adr = 1; mw = 1; end
      K_XR, K_XI: begin
        sa = 2'b10;
        sb = (k == K_XI) ? 2'b01 : 2'b00;
        if (f3 == 3'd0)      alu = (k == K_XR && f7) ? 3'b001 : 3'b000;
        else if (f3 == 3'd2) alu = 3'b101;
        else if (f3 == 3'd6) alu = 3'b011;
        else                 alu = 3'b010;
      end
      K_WB:   rw = 1;
      K_BEQ:  begin sa = 2'b10; alu = 3'b001; pcw = z; end
      K_JAL:  begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      K_TRAP: ill = 1;
      default: ;
    endcase
    return {pcw, adr, mw, irw, rw, res, sa, sb, imm, alu, ill};
  endfunction

  always @(negedge clk) begin
    vec_t e;
    kind_e k;
    if (q0.size() != 0) begin
      e = q0.pop_front(); k = k0q.pop_front(); tests++;
      if (vec0 !== e) begin
        fails++;
        $display("FAIL notrap %s op=%b f3=%b: got %h want %h", k.name(), op, funct3, vec0, e);
      end
    end
    if (q1.size() != 0) begin
      e = q1.pop_front(); k = k1q.pop_front(); tests++;
      if (vec1 !== e) begin
        fails++;
        $display("FAIL trap %s op=%b f3=%b: got %h want %h", k.name(), op, funct3, vec1, e);
      end
    end
  end

  task automatic push(kind_e k0, kind_e k1, int zsel);
    logic z;
    z = (zsel == 2) ? 1'($urandom_range(0, 1)) : 1'(zsel);
    Zero = z;
    q0.push_back(expect_out(k0, op, funct3, funct7b5, z)); k0q.push_back(k0);
    q1.push_back(expect_out(k1, op, funct3, funct7b5, z)); k1q.push_back(k1);
  endtask

  task automatic cycle(kind_e k0, kind_e k1, int zsel);
    push(k0, k1, zsel);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(K_RST, K_RST, 2);
    cycle(K_RST, K_RST, 2);
    reset = 1'b0;
  endtask

  task automatic issue(logic [31:0] instr, int zsel);
    kind_e ks[$];
    kind_e k;
    op = instr[6:0]; funct3 = instr[14:12]; funct7b5 = instr[30];
    if (!legal(op, funct3)) begin
      cycle(K_F, K_F, zsel);
      cycle(K_D, K_D, zsel);
      for (int i = 0; i < 12; i++) begin
        k = (i % 2 == 0) ? K_F : K_D;
        cycle(k, K_TRAP, zsel);
      end
      do_reset();
    end else begin
      ks = {K_F, K_D};
      case (op)
        OP_LW:   begin ks.push_back(K_MA); ks.push_back(K_MR); ks.push_back(K_MWB); end
        OP_SW:   begin ks.push_back(K_MA); ks.push_back(K_MW); end
        OP_R:    begin ks.push_back(K_XR); ks.push_back(K_WB); end
        OP_I:    begin ks.push_back(K_XI); ks.push_back(K_WB); end
        OP_BEQ:  ks.push_back(K_BEQ);
        default: begin ks.push_back(K_JAL); ks.push_back(K_WB); end
      endcase
      foreach (ks[i]) cycle(ks[i], ks[i], zsel);
    end
  endtask

  // Async reset landing between edges while executing an R-type instruction.
  task automatic reset_mid_exec();
    vec_t e;
    op = OP_R; funct3 = 3'd0; funct7b5 = 1'b1;
    cycle(K_F, K_F, 2);
    cycle(K_D, K_D, 2);
    push(K_XR, K_XR, 0);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    e = expect_out(K_RST, op, funct3, funct7b5, Zero);
    tests++;
    if (vec0 !== e) begin fails++; $display("FAIL async_reset notrap: got %h want %h", vec0, e); end
    tests++;
    if (vec1 !== e) begin fails++; $display("FAIL async_reset trap: got %h want %h", vec1, e); end
    @(posedge clk); #1;
    cycle(K_RST, K_RST, 2);
    reset = 1'b0;
  endtask

  initial begin
    logic [6:0] ops [6];
    logic [31:0] instr;
    logic [2:0] f3s [4];
    int c;
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};
    f3s = '{3'd0, 3'd2, 3'd6, 3'd7};
    reset = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; Zero = 1'b0;
    @(posedge clk); #1;
    do_reset();

    issue(32'h002081B3, 2);  // add
    issue(32'h402081B3, 2);  // sub
    issue(32'h40008093, 2);  // addi, instr[30]=1
    issue(32'h0020A1B3, 2);  // slt
    issue(32'h0020E1B3, 2);  // or
    issue(32'h0020F193, 2);  // andi
    issue(32'h00208463, 1);  // beq taken
    issue(32'h00208463, 0);  // beq not taken
    issue(32'h0000A183, 2);  // lw
    issue(32'h0020A223, 2);  // sw
    issue(32'h008000EF, 2);  // jal
    issue(32'h00000000, 2);  // illegal opcode
    issue(32'h002091B3, 2);  // R with illegal funct3
    reset_mid_exec();
    issue(32'h002081B3, 2);

    for (int n = 0; n < 300; n++) begin
      c = $urandom_range(0, 19);
      instr = $urandom;
      instr[6:0] = (c < 18) ? ops[c % 6] : 7'($urandom);
      if ($urandom_range(0, 15) != 0) begin
        if (instr[6:0] == OP_R || instr[6:0] == OP_I) instr[14:12] = f3s[$urandom_range(0, 3)];
        else if (instr[6:0] == OP_LW || instr[6:0] == OP_SW) instr[14:12] = 3'd2;
        else if (instr[6:0] == OP_BEQ) instr[14:12] = 3'd0;
      end
      issue(instr, 2);
    end

    @(negedge clk); #1;
    tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d/%0d pending want 0/0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
